// File: rtl/alu_core_if.sv
// Execute-stage ALU bus: operands and operation select in, registered result and flags out.
interface alu_core_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] data_r1;
  logic [WIDTH-1:0] data_r2;
  logic             ALUControl;
  logic             out_valid;
  logic [WIDTH-1:0] ALUResult;
  logic             Negative;
  logic             Zero;
  logic             Carry;
  logic             Overflow;

  modport master (
    output in_valid, data_r1, data_r2, ALUControl,
    input  out_valid, ALUResult, Negative, Zero, Carry, Overflow
  );

  modport slave (
    input  in_valid, data_r1, data_r2, ALUControl,
    output out_valid, ALUResult, Negative, Zero, Carry, Overflow
  );
endinterface

// File: rtl/alu_core.sv
// Registered add/subtract ALU with NZCV flags; one-cycle latency, one result per cycle.
module alu_core #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_core_if.slave bus
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result_d;
  logic             ovf_d;

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             neg_q;
  logic             zero_q;
  logic             carry_q;
  logic             ovf_q;

  // Subtract reuses the adder as A + ~B + 1, so carry-out means "no borrow".
  always_comb begin
    b_eff    = bus.ALUControl ? ~bus.data_r2 : bus.data_r2;
    sum      = {1'b0, bus.data_r1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.ALUControl};
    result_d = sum[WIDTH-1:0];
    ovf_d    = (bus.data_r1[WIDTH-1] == b_eff[WIDTH-1]) &&
               (result_d[WIDTH-1] != bus.data_r1[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= result_d;
        neg_q    <= result_d[WIDTH-1];
        zero_q   <= ~|result_d;
        carry_q  <= sum[WIDTH];
        ovf_q    <= ovf_d;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.ALUResult = result_q;
  assign bus.Negative  = neg_q;
  assign bus.Zero      = zero_q;
  assign bus.Carry     = carry_q;
  assign bus.Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core with hand-computed expected results and flags.
module tb_alu_core;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  alu_core_if #(.WIDTH(WIDTH)) bus ();

  alu_core #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic vld, input logic [WIDTH-1:0] res,
                           input logic n, input logic z, input logic c, input logic v);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(vld));
    check({tag, ".res"},   64'(bus.ALUResult), 64'(res));
    check({tag, ".N"},     64'(bus.Negative),  64'(n));
    check({tag, ".Z"},     64'(bus.Zero),      64'(z));
    check({tag, ".C"},     64'(bus.Carry),     64'(c));
    check({tag, ".V"},     64'(bus.Overflow),  64'(v));
  endtask

  // Drive one operation between edges, then sample just after the capturing edge.
  task automatic op(input logic vld, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                    input logic sub);
    @(negedge clk);
    bus.in_valid   = vld;
    bus.data_r1    = a;
    bus.data_r2    = b;
    bus.ALUControl = sub;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.data_r1    = '0;
    bus.data_r2    = '0;
    bus.ALUControl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    op(1'b1, 32'd10, 32'd5, 1'b0);
    check_all("add10_5", 1'b1, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b1, 32'd15, 32'd14, 1'b0);
    check_all("add15_14", 1'b1, 32'd29, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b1, 32'd15, 32'd14, 1'b1);
    check_all("sub15_14", 1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    op(1'b1, 32'd4, 32'd8, 1'b1);
    check_all("sub4_8", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    check_all("add_maxpos", 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_all("add_wrap", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    op(1'b1, 32'h8000_0000, 32'd1, 1'b1);
    check_all("sub_minneg", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    op(1'b1, 32'd7, 32'd7, 1'b1);
    check_all("sub7_7", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Idle cycles with changing and unknown operands must leave the outputs held.
    op(1'b0, 32'h1234_5678, 32'h0000_0001, 1'b0);
    check_all("hold1", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    op(1'b0, 'x, 'x, 1'bx);
    check_all("hold2", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

    op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check_all("add_negneg", 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    op(1'b1, 32'd3, 32'hFFFF_FFFF, 1'b1);
    check_all("sub3_m1", 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-run asynchronous reset with an operation pending.
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.data_r1    = 32'hFFFF_FFF0;
    bus.data_r2    = 32'd1;
    bus.ALUControl = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_held", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b1, 32'hFFFF_FFF0, 32'd1, 1'b0);
    check_all("post_rst", 1'b1, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b0, 32'd0, 32'd0, 1'b0);
    check_all("post_idle", 1'b0, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
